multicycle_control: RTL and testbench
=====================================

# multicycle_control

Moore-style control FSM for the multi-cycle MIPS datapath. The datapath shares one memory, one ALU and the IR/MDR/A/B/ALUOut registers. Each instruction is sequenced over 3–5 cycles from the 6-bit opcode held in IR. The block sits between IR[31:26] and the datapath mux selects and write enables. It optionally stalls on a memory-ready handshake.

## Interface
- No parameters. State encoding and ALUOp codes are fixed below.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- OP  in  6  opcode from IR[31:26]. Stable from DECODE until the next FETCH completes.
- MemReady  in  1  memory access complete this cycle (used only with the handshake macro).
- PCWrite  out  1  unconditional PC load.
- PCWriteCondEQ / PCWriteCondNE  out  1 each  PC load qualified by ALU zero / not-zero.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead / MemWrite  out  1 each  memory strobes.
- IRWrite  out  1  IR load.
- MemtoReg  out  2  register write-data select: 00 = ALUOut, 01 = MDR, 10 = PC.
- RegDst  out  2  destination select: 00 = rt, 01 = rd, 10 = $31.
- RegWrite  out  1  register-file write.
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = A.
- ALUSrcB  out  2  ALU B input: 00 = B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- PCSource  out  2  PC input: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- ALUOp  out  3  ALU control code.
- IllegalOp  out  1  one-cycle pulse on an unsupported opcode.
- State  out  4  current state, for debug.

## Operation
- Supported opcodes: R 0x00, ADDI 0x08, ANDI 0x0C, ORI 0x0D, LUI 0x0F, LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05, J 0x02, JAL 0x03.
- ALUOp codes: R 111, ADDI 110, ANDI 011, LUI 001, ORI 101, add (address / PC) 010, subtract (branch) 100.
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, ALU_WB=7, BRANCH=8, JUMP=9, JAL=10. Any other encoding returns to FETCH.
- Outputs per state. Every signal not listed is 0.
  - FETCH: MemRead, IRWrite, PCWrite, ALUSrcB=01, ALUOp=010, IorD=0, PCSource=00.
  - DECODE: ALUSrcB=11, ALUOp=010. This precomputes the branch target into ALUOut.
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=010.
  - MEM_RD: MemRead, IorD=1.
  - MEM_WB: RegWrite, MemtoReg=01, RegDst=00.
  - MEM_WR: MemWrite, IorD=1.
  - EXEC: ALUSrcA=1; ALUSrcB=00 for R-type, 10 otherwise; ALUOp from the opcode table.
  - ALU_WB: RegWrite, MemtoReg=00; RegDst=01 for R-type, 00 otherwise.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=100, PCSource=01; PCWriteCondEQ for BEQ, PCWriteCondNE for BNE.
  - JUMP: PCWrite, PCSource=10.
  - JAL: PCWrite, PCSource=10, RegWrite, RegDst=10, MemtoReg=10. PC still holds PC+4 this cycle, so $31 receives the return address.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEM_ADDR for LW/SW, EXEC for R-type and ALU-immediates, BRANCH for BEQ/BNE, JUMP for J, JAL for JAL.
  - DECODE→FETCH for any other opcode, with IllegalOp=1 during DECODE. The instruction is discarded and the PC stays advanced.
  - MEM_ADDR→MEM_RD for LW, MEM_WR for SW.
  - MEM_RD→MEM_WB.
  - EXEC→ALU_WB.
  - MEM_WB, MEM_WR, ALU_WB, BRANCH, JUMP and JAL all →FETCH.

## Timing
- Reset low: State=FETCH immediately, and every output is forced to 0 while reset is low. This includes MemRead, IRWrite and PCWrite.
- The first FETCH strobes appear in the first cycle after reset deasserts.
- Outputs are combinational from the registered state and OP. No output depends on MemReady except as noted under Configuration.
- Latency without stalls:
  - LW: 5 cycles.
  - R-type, ALU-immediate, SW: 4 cycles.
  - BEQ, BNE, J, JAL: 3 cycles.
- Reset asserted in any state aborts the instruction within the same cycle. No partial write completes after the next clock edge.

## Configuration
- Macro: MC_MEM_HANDSHAKE_EN.
- Defined:
  - FETCH, MEM_RD and MEM_WR hold until MemReady=1.
  - MemRead/MemWrite stay high for the whole wait.
  - In FETCH, IRWrite and PCWrite are asserted only in the cycle where MemReady=1.
  - MEM_RD advances to MEM_WB only after MemReady=1.
  - MemReady=1 on the first cycle of a memory state means zero wait.
- Undefined: MemReady is ignored and treated as 1. Every state lasts exactly one cycle.

## Test plan
- Reset low for 3 cycles, then release → outputs all 0 and State=0 while reset is low. In the first cycle after release: MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
- OP=0x23 (LW) → State sequence 0,1,2,3,4,0. In state 4: RegWrite=1, MemtoReg=01, RegDst=00.
- OP=0x00, then OP=0x0D → State sequence 0,1,6,7,0 each time.
  - R-type: ALUOp=111 and ALUSrcB=00 in EXEC; RegDst=01 in ALU_WB.
  - ORI: ALUOp=101 and ALUSrcB=10 in EXEC; RegDst=00 in ALU_WB.
- OP=0x05 (BNE) → only PCWriteCondNE is high in BRANCH, with PCSource=01. OP=0x03 (JAL) → in JAL: RegWrite=1, RegDst=10, MemtoReg=10, PCWrite=1.
- OP=0x3F → IllegalOp pulses for exactly 1 cycle in DECODE, next State=0, and no RegWrite or MemWrite is asserted.
- With MC_MEM_HANDSHAKE_EN and SW: hold MemReady=0 for 4 cycles in MEM_WR → MemWrite stays high for 5 cycles and State stays 5 until MemReady=1, then returns to 0. Assert reset mid-wait → all outputs 0 in the same cycle.

Source files
------------

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Moore-style control FSM for the multi-cycle MIPS datapath. The datapath
// shares one memory, one ALU and the IR/MDR/A/B/ALUOut registers. This block
// sequences each instruction over 3-5 cycles from the opcode held in IR. It
// drives the datapath mux selects and write enables.
//
// Optional feature macro: MC_MEM_HANDSHAKE_EN
//   Defined   : FETCH, MEM_RD and MEM_WR hold until MemReady=1.
//               In FETCH, IRWrite and PCWrite fire only in the ready cycle.
//   Undefined : MemReady is ignored and every state lasts one cycle.
//
// Ports
//   clk            in   1  system clock, rising edge
//   reset          in   1  asynchronous active-low reset
//   OP             in   6  opcode from IR[31:26]
//   MemReady       in   1  memory access completes this cycle
//   PCWrite        out  1  unconditional PC load
//   PCWriteCondEQ  out  1  PC load when ALU zero
//   PCWriteCondNE  out  1  PC load when ALU not zero
//   IorD           out  1  memory address: 0 = PC, 1 = ALUOut
//   MemRead        out  1  memory read strobe
//   MemWrite       out  1  memory write strobe
//   IRWrite        out  1  IR load
//   MemtoReg       out  2  write data: 00 = ALUOut, 01 = MDR, 10 = PC
//   RegDst         out  2  destination: 00 = rt, 01 = rd, 10 = $31
//   RegWrite       out  1  register-file write
//   ALUSrcA        out  1  ALU A: 0 = PC, 1 = A
//   ALUSrcB        out  2  ALU B: 00 = B, 01 = 4, 10 = imm, 11 = imm<<2
//   PCSource       out  2  PC input: 00 = ALU, 01 = ALUOut, 10 = jump target
//   ALUOp          out  3  ALU control code
//   IllegalOp      out  1  one-cycle pulse on an unsupported opcode
//   State          out  4  current state (debug)
// ---------------------------------------------------------------------------
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCondEQ,
  output logic       PCWriteCondNE,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] MemtoReg,
  output logic [1:0] RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALUOp,
  output logic       IllegalOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  // ALU control code for the EXEC cycle of R-type and ALU-immediate ops.
  function automatic logic [2:0] aluOpFor(input logic [5:0] opc);
    logic [2:0] code;
    case (opc)
      OP_R:    code = 3'b111;
      OP_ADDI: code = 3'b110;
      OP_ANDI: code = 3'b011;
      OP_ORI:  code = 3'b101;
      OP_LUI:  code = 3'b001;
      default: code = 3'b000;
    endcase
    return code;
  endfunction

  state_t curState_r;
  state_t nextState_s;
  logic   memReady_s;
  logic   isRType_s;

`ifdef MC_MEM_HANDSHAKE_EN
  assign memReady_s = MemReady;
`else
  // MemReady is ignored in this build. OR-ing in the constant keeps the port
  // referenced while the result always folds to 1.
  assign memReady_s = MemReady | 1'b1;
`endif

  assign isRType_s = (OP == OP_R);

  // State register. Reset forces FETCH immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      curState_r <= S_FETCH;
    end else begin
      curState_r <= nextState_s;
    end
  end

  // Next-state and Moore outputs. All outputs are forced low while reset is
  // held, so an aborted instruction can never issue a write.
  always_comb begin
    nextState_s   = S_FETCH;
    PCWrite       = 1'b0;
    PCWriteCondEQ = 1'b0;
    PCWriteCondNE = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    MemtoReg      = 2'b00;
    RegDst        = 2'b00;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    PCSource      = 2'b00;
    ALUOp         = 3'b000;
    IllegalOp     = 1'b0;
    State         = 4'd0;
    if (!reset) begin
      nextState_s = S_FETCH;
    end else begin
      State = curState_r;
      case (curState_r)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          ALUOp   = 3'b010;
          // IR and PC advance only when the instruction word is actually here.
          IRWrite = memReady_s;
          PCWrite = memReady_s;
          if (memReady_s) begin
            nextState_s = S_DECODE;
          end else begin
            nextState_s = S_FETCH;
          end
        end
        S_DECODE: begin
          // Branch target precomputed into ALUOut here.
          ALUSrcB = 2'b11;
          ALUOp   = 3'b010;
          case (OP)
            OP_LW, OP_SW:                           nextState_s = S_MEM_ADDR;
            OP_R, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: nextState_s = S_EXEC;
            OP_BEQ, OP_BNE:                         nextState_s = S_BRANCH;
            OP_J:                                   nextState_s = S_JUMP;
            OP_JAL:                                 nextState_s = S_JAL;
            default: begin
              IllegalOp   = 1'b1;
              nextState_s = S_FETCH;
            end
          endcase
        end
        S_MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp   = 3'b010;
          if (OP == OP_LW) begin
            nextState_s = S_MEM_RD;
          end else if (OP == OP_SW) begin
            nextState_s = S_MEM_WR;
          end else begin
            nextState_s = S_FETCH;
          end
        end
        S_MEM_RD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          if (memReady_s) begin
            nextState_s = S_MEM_WB;
          end else begin
            nextState_s = S_MEM_RD;
          end
        end
        S_MEM_WB: begin
          RegWrite    = 1'b1;
          MemtoReg    = 2'b01;
          RegDst      = 2'b00;
          nextState_s = S_FETCH;
        end
        S_MEM_WR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          if (memReady_s) begin
            nextState_s = S_FETCH;
          end else begin
            nextState_s = S_MEM_WR;
          end
        end
        S_EXEC: begin
          ALUSrcA     = 1'b1;
          ALUSrcB     = isRType_s ? 2'b00 : 2'b10;
          ALUOp       = aluOpFor(OP);
          nextState_s = S_ALU_WB;
        end
        S_ALU_WB: begin
          RegWrite    = 1'b1;
          MemtoReg    = 2'b00;
          RegDst      = isRType_s ? 2'b01 : 2'b00;
          nextState_s = S_FETCH;
        end
        S_BRANCH: begin
          ALUSrcA       = 1'b1;
          ALUSrcB       = 2'b00;
          ALUOp         = 3'b100;
          PCSource      = 2'b01;
          PCWriteCondEQ = (OP == OP_BEQ);
          PCWriteCondNE = (OP == OP_BNE);
          nextState_s   = S_FETCH;
        end
        S_JUMP: begin
          PCWrite     = 1'b1;
          PCSource    = 2'b10;
          nextState_s = S_FETCH;
        end
        S_JAL: begin
          // PC still holds PC+4 here, so $31 gets the return address.
          PCWrite     = 1'b1;
          PCSource    = 2'b10;
          RegWrite    = 1'b1;
          RegDst      = 2'b10;
          MemtoReg    = 2'b10;
          nextState_s = S_FETCH;
        end
        default: begin
          nextState_s = S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//
// Self-checking bench for multicycle_control. A behavioural model maps each
// opcode to its instruction class. From the class it derives the expected
// state trace and the control word for each cycle. Directed steps come
// first, then a randomized instruction stream. Handshake stalls are covered
// when MC_MEM_HANDSHAKE_EN is defined.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OP;
  logic       MemReady;
  logic       PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite;
  logic [1:0] MemtoReg, RegDst;
  logic       RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic       IllegalOp;
  logic [3:0] State;

  int checks   = 0;
  int failures = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .OP(OP), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCondEQ(PCWriteCondEQ), .PCWriteCondNE(PCWriteCondNE),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp), .IllegalOp(IllegalOp),
    .State(State)
  );

  always #5 clk = ~clk;

  // Instruction classes
  localparam int C_LW = 0, C_SW = 1, C_ALU = 2, C_BR = 3, C_J = 4, C_JAL = 5, C_ILL = 6;

  function automatic int classOf(input logic [5:0] op);
    case (op)
      6'h23:                             return C_LW;
      6'h2B:                             return C_SW;
      6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0F: return C_ALU;
      6'h04, 6'h05:                      return C_BR;
      6'h02:                             return C_J;
      6'h03:                             return C_JAL;
      default:                           return C_ILL;
    endcase
  endfunction

  function automatic int seqLen(input logic [5:0] op);
    case (classOf(op))
      C_LW:          return 5;
      C_SW, C_ALU:   return 4;
      C_ILL:         return 2;
      default:       return 3;
    endcase
  endfunction

  function automatic int seqState(input logic [5:0] op, input int k);
    int tr[5];
    case (classOf(op))
      C_LW:    tr = '{0, 1, 2, 3, 4};
      C_SW:    tr = '{0, 1, 2, 5, 0};
      C_ALU:   tr = '{0, 1, 6, 7, 0};
      C_BR:    tr = '{0, 1, 8, 0, 0};
      C_J:     tr = '{0, 1, 9, 0, 0};
      C_JAL:   tr = '{0, 1, 10, 0, 0};
      default: tr = '{0, 1, 0, 0, 0};
    endcase
    return tr[k];
  endfunction

  function automatic logic [2:0] expAlu(input logic [5:0] op);
    case (op)
      6'h00:   return 3'b111;
      6'h08:   return 3'b110;
      6'h0C:   return 3'b011;
      6'h0D:   return 3'b101;
      6'h0F:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // Expected control word for cycle type st. The field order matches obsVec.
  function automatic logic [20:0] expCtrl(input int st, input logic [5:0] op);
    logic pcw, ceq, cne, iord, mr, mw, irw, rw, srca, ill;
    logic [1:0] m2r, rdst, srcb, pcs;
    logic [2:0] aop;
    {pcw, ceq, cne, iord, mr, mw, irw, rw, srca, ill} = 10'd0;
    {m2r, rdst, srcb, pcs} = 8'd0;
    aop = 3'd0;
    case (st)
      0:  begin mr = 1'b1; irw = 1'b1; pcw = 1'b1; srcb = 2'b01; aop = 3'b010; end
      1:  begin srcb = 2'b11; aop = 3'b010; ill = (classOf(op) == C_ILL); end
      2:  begin srca = 1'b1; srcb = 2'b10; aop = 3'b010; end
      3:  begin mr = 1'b1; iord = 1'b1; end
      4:  begin rw = 1'b1; m2r = 2'b01; end
      5:  begin mw = 1'b1; iord = 1'b1; end
      6:  begin srca = 1'b1; srcb = (op == 6'h00) ? 2'b00 : 2'b10; aop = expAlu(op); end
      7:  begin rw = 1'b1; rdst = (op == 6'h00) ? 2'b01 : 2'b00; end
      8:  begin srca = 1'b1; aop = 3'b100; pcs = 2'b01; ceq = (op == 6'h04); cne = (op == 6'h05); end
      9:  begin pcw = 1'b1; pcs = 2'b10; end
      10: begin pcw = 1'b1; pcs = 2'b10; rw = 1'b1; rdst = 2'b10; m2r = 2'b10; end
      default: ;
    endcase
    return {pcw, ceq, cne, iord, mr, mw, irw, m2r, rdst, rw, srca, srcb, pcs, aop, ill};
  endfunction

  function automatic logic [24:0] obsVec();
    return {State, PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite,
            MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, IllegalOp};
  endfunction

  task automatic check(input string tag, input logic [24:0] obs, input logic [24:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered at a falling edge while in FETCH. Leaves at the next FETCH.
  task automatic runInstr(input logic [5:0] op);
    int st;
    OP = op;
    for (int k = 0; k < seqLen(op); k++) begin
      st = seqState(op, k);
      #1;
      check($sformatf("op%02h_step%0d", op, k), obsVec(), {4'(st), expCtrl(st, op)});
      @(negedge clk);
    end
  endtask

  logic [5:0] opTable [11];

  initial begin
    opTable = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
    reset    = 1'b0;
    OP       = 6'h00;
    MemReady = 1'b1;

    // Reset held for three cycles: everything low.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset_low_%0d", i), obsVec(), 25'd0);
    end
    reset = 1'b1;
    #1;
    check("first_fetch", obsVec(), {4'd0, expCtrl(0, 6'h00)});
    #1;
    runInstr(6'h00);   // completes the first instruction (check repeats FETCH)

    // Directed instructions from the test plan.
    runInstr(6'h23);   // LW
    runInstr(6'h00);   // R-type
    runInstr(6'h0D);   // ORI
    runInstr(6'h05);   // BNE
    runInstr(6'h03);   // JAL
    runInstr(6'h3F);   // illegal
    runInstr(6'h04);   // BEQ
    runInstr(6'h2B);   // SW
    runInstr(6'h02);   // J
    runInstr(6'h0F);   // LUI

    // Reset during MEM_WB of an LW aborts the write in the same cycle.
    OP = 6'h23;
    repeat (4) @(negedge clk);
    #1;
    check("lw_in_memwb", obsVec(), {4'd4, expCtrl(4, 6'h23)});
    reset = 1'b0;
    #1;
    check("abort_memwb", obsVec(), 25'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("refetch_after_abort", obsVec(), {4'd0, expCtrl(0, 6'h23)});
    @(negedge clk);
    check("decode_after_abort", obsVec(), {4'd1, expCtrl(1, 6'h23)});
    repeat (4) @(negedge clk);

    // Random instruction stream. Roughly one in five opcodes is fully random.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        runInstr(6'($urandom_range(0, 63)));
      end else begin
        runInstr(opTable[$urandom_range(0, 10)]);
      end
    end

`ifdef MC_MEM_HANDSHAKE_EN
    // Fetch stall: read stays up while IR and PC loads wait for ready.
    OP = 6'h2B;
    MemReady = 1'b0;
    #1;
    check("fetch_stall", obsVec(),
          {4'd0, expCtrl(0, 6'h2B) & ~(21'h1 << 20) & ~(21'h1 << 14)});
    @(negedge clk);
    check("fetch_still_waiting", obsVec(),
          {4'd0, expCtrl(0, 6'h2B) & ~(21'h1 << 20) & ~(21'h1 << 14)});
    MemReady = 1'b1;
    #1;
    check("fetch_ready", obsVec(), {4'd0, expCtrl(0, 6'h2B)});
    @(negedge clk);
    // SW with a four-cycle write stall.
    check("sw_decode", obsVec(), {4'd1, expCtrl(1, 6'h2B)});
    @(negedge clk);
    check("sw_memaddr", obsVec(), {4'd2, expCtrl(2, 6'h2B)});
    @(negedge clk);
    MemReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("sw_wait_%0d", i), obsVec(), {4'd5, expCtrl(5, 6'h2B)});
      @(negedge clk);
    end
    MemReady = 1'b1;
    #1;
    check("sw_ready", obsVec(), {4'd5, expCtrl(5, 6'h2B)});
    @(negedge clk);
    check("sw_done_fetch", obsVec(), {4'd0, expCtrl(0, 6'h2B)});
    // Reset in the middle of a write stall.
    repeat (3) @(negedge clk);
    MemReady = 1'b0;
    repeat (2) @(negedge clk);
    check("sw_wait_before_abort", obsVec(), {4'd5, expCtrl(5, 6'h2B)});
    reset = 1'b0;
    #1;
    check("abort_memwr", obsVec(), 25'd0);
    @(negedge clk);
    reset    = 1'b1;
    MemReady = 1'b1;
    #1;
    runInstr(6'h23);
    runInstr(6'h05);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
